// File: rtl/or1200_except_ctrl_p.sv
// -----------------------------------------------------------------------------
// or1200_except_ctrl_p
// Parametrised exception controller. It arbitrates NUM_SRC level triggers by
// fixed priority, where the higher index wins. On acceptance it captures
// EPCR, then sequences a pipeline flush:
//   IDLE -> FLU1 -> FLU2 -> DRAIN x (FLUSH_DEPTH-3) -> FINAL -> IDLE
// Triggers that arrive while the flush is running are held in a sticky
// pending register. They are serviced once the FSM is back in IDLE.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   except_trig[NUM_SRC]      raw exception triggers (level)
//   src_mask[NUM_SRC]         per-source arbitration enable
//   pc_we                     SPR PC write; starts a flush with no exception
//   icpu_ack_i, icpu_err_i    instruction bus ack / error
//   genpc_freeze, if_stall,   pipeline freeze / stall status
//   id_freeze, ex_dslot
//   id_pc/ex_pc/dl_pc/wb_pc   stage PCs used as EPCR candidates
//   except_flushpipe          combinational flush request
//   except_start              one-cycle pulse when an exception is accepted
//   except_type               winner index + 1 (0 = none)
//   epcr                      exception PC register
//   pend                      sticky pending triggers
//   state                     0 IDLE, 1 FLU1, 2 FLU2, 3 DRAIN, 4 FINAL
// -----------------------------------------------------------------------------
module or1200_except_ctrl_p #(
  parameter int                   NUM_SRC     = 14,
  parameter int                   FLUSH_DEPTH = 5,
  parameter int                   PC_W        = 32,
  parameter int                   TRAP_IDX    = 8,
  parameter logic [2*NUM_SRC-1:0] PC_SEL      = {NUM_SRC{2'd1}},
  parameter logic [NUM_SRC-1:0]   PEND_EN     = {NUM_SRC{1'b1}},
  parameter int                   TYPE_W      = $clog2(NUM_SRC+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SRC-1:0] except_trig,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic              pc_we,
  input  logic              icpu_ack_i,
  input  logic              icpu_err_i,
  input  logic              genpc_freeze,
  input  logic              if_stall,
  input  logic              id_freeze,
  input  logic              ex_dslot,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [PC_W-1:0]   dl_pc,
  input  logic [PC_W-1:0]   wb_pc,
  output logic              except_flushpipe,
  output logic              except_start,
  output logic [TYPE_W-1:0] except_type,
  output logic [PC_W-1:0]   epcr,
  output logic [NUM_SRC-1:0] pend,
  output logic [2:0]        state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FLU1  = 3'd1;
  localparam logic [2:0] S_FLU2  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FINAL = 3'd4;

  localparam int CNT_W = $clog2(FLUSH_DEPTH);

  logic [2:0]         state_next;
  logic [TYPE_W-1:0]  type_next;
  logic [PC_W-1:0]    epcr_next;
  logic [NUM_SRC-1:0] pend_next;
  logic               start_next;
  logic [CNT_W-1:0]   cnt, cnt_next;

  logic [NUM_SRC-1:0] req;
  logic               any_req;
  logic [TYPE_W-1:0]  win_idx;
  logic [1:0]         win_sel;
  logic [NUM_SRC-1:0] win_onehot;
  logic [PC_W-1:0]    sel_pc;

  // Pending entries compete with live triggers. Masked ones stay parked.
  assign req     = (except_trig | pend) & src_mask;
  assign any_req = |req;

  // Fixed priority: the ascending scan lets the highest set index win.
  always_comb begin
    win_idx = '0;
    win_sel = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i]) begin
        win_idx = TYPE_W'(i);
        win_sel = PC_SEL[2*i +: 2];
      end
    end
    win_onehot = NUM_SRC'(1) << win_idx;
  end

  always_comb begin
    case (win_sel)
      2'd0:    sel_pc = id_pc;
      2'd1:    sel_pc = ex_pc;
      2'd2:    sel_pc = dl_pc;
      default: sel_pc = wb_pc;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and datapath next values
  always_comb begin
    state_next = state;
    type_next  = except_type;
    epcr_next  = epcr;
    pend_next  = pend;
    start_next = 1'b0;
    cnt_next   = cnt;

    // Outside IDLE every enabled trigger is parked, even if it is masked.
    if (state != S_IDLE)
      pend_next = pend | (except_trig & PEND_EN);

    case (state)
      S_IDLE: begin
        if (any_req) begin
          type_next  = win_idx + TYPE_W'(1);
          // A delay-slot instruction must restart at its branch, already in WB.
          epcr_next  = ex_dslot ? wb_pc : sel_pc;
          // Losers are kept for later. The winner's own pend bit is cleared,
          // so a live trigger and its pend bit are serviced only once.
          pend_next  = (pend | (req & PEND_EN)) & ~win_onehot;
          start_next = 1'b1;
          state_next = S_FLU1;
        end else if (pc_we) begin
          state_next = S_FLU1;
        end
      end
      S_FLU1: begin
        if (icpu_ack_i || icpu_err_i || genpc_freeze)
          state_next = S_FLU2;
      end
      S_FLU2: begin
        if (except_type == TYPE_W'(TRAP_IDX + 1)) begin
          state_next = S_IDLE;
          type_next  = '0;
        end else if (FLUSH_DEPTH == 3) begin
          state_next = S_FINAL;
        end else begin
          state_next = S_DRAIN;
          cnt_next   = CNT_W'(FLUSH_DEPTH - 3);
        end
      end
      S_DRAIN: begin
        // Leave on the edge where the counter reaches zero. With a load of
        // FLUSH_DEPTH-3 this gives exactly that many DRAIN cycles.
        cnt_next = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1))
          state_next = S_FINAL;
      end
      S_FINAL: begin
        if (!if_stall && !id_freeze) begin
          state_next = S_IDLE;
          type_next  = '0;
        end
      end
      default: begin
        state_next = S_IDLE;
        type_next  = '0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      except_type  <= '0;
      epcr         <= '0;
      pend         <= '0;
      except_start <= 1'b0;
      cnt          <= '0;
    end else begin
      except_type  <= type_next;
      epcr         <= epcr_next;
      pend         <= pend_next;
      except_start <= start_next;
      cnt          <= cnt_next;
    end
  end

  // Output logic. A request can only be taken from IDLE.
  always_comb begin
    except_flushpipe = (state == S_IDLE) && any_req;
  end

endmodule
